// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - fetch unit bus: redirect, imem req/ack and IF/ID valid/ready
// Carries inst_misalign_o only when FETCH_ALIGN_CHECK_EN is defined.
interface fetch_pc_unit_if;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        inst_misalign_o;
`endif

  modport master (
    input  branch_flag_i, branch_target_i, imem_ack_i, imem_rdata_i, inst_ready_i,
`ifdef FETCH_ALIGN_CHECK_EN
    output inst_misalign_o,
`endif
    output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_addr_o
  );

  modport slave (
    output branch_flag_i, branch_target_i, imem_ack_i, imem_rdata_i, inst_ready_i,
`ifdef FETCH_ALIGN_CHECK_EN
    input  inst_misalign_o,
`endif
    input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_addr_o
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - PC, imem req/ack fetch FSM and 2-entry fetch queue feeding IF/ID
// Optional redirect-misalignment flag: FETCH_ALIGN_CHECK_EN
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input logic             clk,
  input logic             rst,
  fetch_pc_unit_if.master bus
);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAITQ, S_DROP} state_t;

  state_t           state;
  logic [31:0]      pc;
  logic [31:0]      addr_q;
  logic             req_q;
  logic [CNT_W-1:0] count;
  logic [31:0]      q_inst [QUEUE_DEPTH];
  logic [31:0]      q_addr [QUEUE_DEPTH];

  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count_after;
  logic [31:0]      target;
  logic [31:0]      pc_inc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic [QUEUE_DEPTH-1:0] q_mis;
  logic                   mis_pending;
`endif

  assign target      = bus.branch_target_i & 32'hFFFF_FFFC;
  assign pc_inc      = pc + 32'd4;
  assign pop         = (count != '0) && bus.inst_ready_i;
  assign push        = (state == S_REQ) && bus.imem_ack_i && !bus.branch_flag_i;
  assign count_after = count + CNT_W'(push) - CNT_W'(pop);

  assign bus.imem_req_o   = req_q;
  assign bus.imem_addr_o  = addr_q;
  assign bus.inst_valid_o = (count != '0);
  assign bus.inst_o       = q_inst[0];
  assign bus.inst_addr_o  = q_addr[0];
`ifdef FETCH_ALIGN_CHECK_EN
  assign bus.inst_misalign_o = q_mis[0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
      req_q  <= 1'b0;
      count  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_inst[i] <= '0;
        q_addr[i] <= '0;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      q_mis       <= '0;
      mis_pending <= 1'b0;
`endif
    end else if (bus.branch_flag_i) begin
      pc    <= target;
      count <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      q_mis       <= '0;
      mis_pending <= |bus.branch_target_i[1:0];
`endif
      // An unacked fetch must still complete on its old address; its data is dropped later.
      if ((state == S_REQ || state == S_DROP) && !bus.imem_ack_i) begin
        state <= S_DROP;
      end else begin
        state  <= S_REQ;
        req_q  <= 1'b1;
        addr_q <= target;
      end
    end else begin
      case ({push, pop})
        2'b10: begin
          q_inst[count[0]] <= bus.imem_rdata_i;
          q_addr[count[0]] <= addr_q;
`ifdef FETCH_ALIGN_CHECK_EN
          q_mis[count[0]] <= mis_pending;
          mis_pending     <= 1'b0;
`endif
        end
        2'b01: begin
          q_inst[0] <= q_inst[1];
          q_addr[0] <= q_addr[1];
`ifdef FETCH_ALIGN_CHECK_EN
          q_mis <= {1'b0, q_mis[1]};
`endif
        end
        2'b11: begin
          if (count == CNT_W'(1)) begin
            q_inst[0] <= bus.imem_rdata_i;
            q_addr[0] <= addr_q;
`ifdef FETCH_ALIGN_CHECK_EN
            q_mis[0] <= mis_pending;
`endif
          end else begin
            q_inst[0] <= q_inst[1];
            q_addr[0] <= q_addr[1];
            q_inst[1] <= bus.imem_rdata_i;
            q_addr[1] <= addr_q;
`ifdef FETCH_ALIGN_CHECK_EN
            q_mis <= {mis_pending, q_mis[1]};
`endif
          end
`ifdef FETCH_ALIGN_CHECK_EN
          mis_pending <= 1'b0;
`endif
        end
        default: ;
      endcase
      count <= count_after;

      case (state)
        S_IDLE: begin
          state  <= S_REQ;
          req_q  <= 1'b1;
          addr_q <= pc;
        end
        S_REQ: begin
          if (bus.imem_ack_i) begin
            pc <= pc_inc;
            // Only keep requesting while the queue can still absorb the next word.
            if (count_after <= CNT_W'(1)) begin
              addr_q <= pc_inc;
            end else begin
              state <= S_WAITQ;
              req_q <= 1'b0;
            end
          end
        end
        S_WAITQ: begin
          if (count_after < CNT_W'(QUEUE_DEPTH)) begin
            state  <= S_REQ;
            req_q  <= 1'b1;
            addr_q <= pc;
          end
        end
        S_DROP: begin
          if (bus.imem_ack_i) begin
            state  <= S_REQ;
            addr_q <= pc;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed and randomized checks of fetch_pc_unit against a queue model
module tb_fetch_pc_unit;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] a;
    bit          m;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   mem_lat = 0;
  bit   mem_rand = 1'b0;
  bit   mem_busy = 1'b0;
  int   wait_left = 0;

  fetch_pc_unit_if bus();
  fetch_pc_unit_if bus2();

  fetch_pc_unit dut (.clk(clk), .rst(rst), .bus(bus));
  fetch_pc_unit #(.RESET_PC(WRAP_PC)) dut_wrap (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] addr);
    return {addr[15:0], addr[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic mem_drive();
    if (rst || !bus.imem_req_o) begin
      bus.imem_ack_i   = 1'b0;
      bus.imem_rdata_i = $urandom;
      mem_busy         = 1'b0;
    end else begin
      if (!mem_busy) begin
        mem_busy  = 1'b1;
        wait_left = mem_rand ? int'($urandom_range(0, 2)) : mem_lat;
      end
      if (wait_left == 0) begin
        bus.imem_ack_i   = 1'b1;
        bus.imem_rdata_i = word_of(bus.imem_addr_o);
        mem_busy         = 1'b0;
      end else begin
        bus.imem_ack_i   = 1'b0;
        bus.imem_rdata_i = $urandom;
        wait_left--;
      end
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst                 = 1'b1;
    bus.imem_ack_i      = 1'b0;
    bus.branch_flag_i   = 1'b0;
    bus2.imem_ack_i     = 1'b0;
    bus2.branch_flag_i  = 1'b0;
    mem_busy            = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #100;
    n_checks++; if (bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", bus.imem_req_o); end
    n_checks++; if (bus.imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", bus.imem_addr_o); end
    n_checks++; if (bus.inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", bus.inst_valid_o); end
    n_checks++; if (bus.inst_o !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h expected 0", bus.inst_o); end
    n_checks++; if (bus.inst_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_inst_addr: got %h expected 0", bus.inst_addr_o); end
    n_checks++; if (bus2.imem_addr_o !== WRAP_PC) begin n_fail++; $display("FAIL rst_addr_wrap: got %h expected %h", bus2.imem_addr_o, WRAP_PC); end
`ifdef FETCH_ALIGN_CHECK_EN
    n_checks++; if (bus.inst_misalign_o !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %b expected 0", bus.inst_misalign_o); end
`endif
    #100;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %b expected 0", bus.imem_req_o); end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      mem_drive();
      n_checks++;
      if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'(4 * k)) begin
        n_fail++; $display("FAIL stream_fetch k=%0d: got req=%b addr=%h expected req=1 addr=%h", k, bus.imem_req_o, bus.imem_addr_o, 32'(4 * k));
      end
      n_checks++;
      if (bus.inst_valid_o !== (k >= 1)) begin
        n_fail++; $display("FAIL stream_valid k=%0d: got %b expected %b", k, bus.inst_valid_o, (k >= 1));
      end
      if (k >= 1) begin
        n_checks++;
        if (bus.inst_addr_o !== 32'(4 * (k - 1)) || bus.inst_o !== word_of(32'(4 * (k - 1)))) begin
          n_fail++; $display("FAIL stream_head k=%0d: got %h/%h expected addr %h", k, bus.inst_addr_o, bus.inst_o, 32'(4 * (k - 1)));
        end
      end
    end
  endtask

  task automatic test_stall_fill();
    bit          er [7] = '{1, 1, 0, 0, 0, 1, 1};
    logic [31:0] ea [7] = '{32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 32'h8, 32'hC};
    bit          ev [7] = '{0, 1, 1, 1, 1, 1, 1};
    logic [31:0] eh [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h8};
    bus.inst_ready_i = 1'b0;
    mem_lat = 0;
    apply_reset(2);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      mem_drive();
      bus.inst_ready_i = (k >= 4);
      n_checks++;
      if (bus.imem_req_o !== er[k] || (er[k] && bus.imem_addr_o !== ea[k])) begin
        n_fail++; $display("FAIL stall_fetch k=%0d: got req=%b addr=%h expected req=%b addr=%h", k, bus.imem_req_o, bus.imem_addr_o, er[k], ea[k]);
      end
      n_checks++;
      if (bus.inst_valid_o !== ev[k] || (ev[k] && (bus.inst_addr_o !== eh[k] || bus.inst_o !== word_of(eh[k])))) begin
        n_fail++; $display("FAIL stall_head k=%0d: got v=%b addr=%h expected v=%b addr=%h", k, bus.inst_valid_o, bus.inst_addr_o, ev[k], eh[k]);
      end
    end
  endtask

  task automatic test_same_cycle_branch();
    logic [31:0] ea [6] = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104, 32'h108};
    bit          ev [6] = '{0, 1, 1, 0, 1, 1};
    logic [31:0] eh [6] = '{32'h0, 32'h0, 32'h4, 32'h0, 32'h100, 32'h104};
    bus.inst_ready_i = 1'b1;
    apply_reset(2);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      mem_drive();
      bus.branch_flag_i   = (k == 2);
      bus.branch_target_i = 32'h100;
      n_checks++;
      if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== ea[k] || bus.imem_ack_i !== 1'b1) begin
        n_fail++; $display("FAIL scb_fetch k=%0d: got req=%b addr=%h expected addr=%h", k, bus.imem_req_o, bus.imem_addr_o, ea[k]);
      end
      n_checks++;
      if (bus.inst_valid_o !== ev[k] || (ev[k] && (bus.inst_addr_o !== eh[k] || bus.inst_o !== word_of(eh[k])))) begin
        n_fail++; $display("FAIL scb_head k=%0d: got v=%b addr=%h expected v=%b addr=%h", k, bus.inst_valid_o, bus.inst_addr_o, ev[k], eh[k]);
      end
    end
    bus.branch_flag_i = 1'b0;
  endtask

  task automatic test_drop();
    bit got;
    bus.inst_ready_i = 1'b1;
    mem_lat = 3;
    apply_reset(2);
    @(negedge clk);
    mem_drive();
    n_checks++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0 || bus.imem_ack_i !== 1'b0) begin
      n_fail++; $display("FAIL drop_first_wait: got req=%b addr=%h ack=%b expected 1/0/0", bus.imem_req_o, bus.imem_addr_o, bus.imem_ack_i);
    end
    bus.branch_flag_i   = 1'b1;
    bus.branch_target_i = 32'h200;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      bus.branch_flag_i = 1'b0;
      mem_drive();
      n_checks++;
      if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin
        n_fail++; $display("FAIL drop_hold k=%0d: got req=%b addr=%h expected 1/0", k, bus.imem_req_o, bus.imem_addr_o);
      end
      n_checks++;
      if (bus.inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL drop_valid_old k=%0d: got %b expected 0", k, bus.inst_valid_o); end
      got = bus.imem_ack_i;
    end
    n_checks++; if (!got) begin n_fail++; $display("FAIL drop_old_ack: got no ack expected ack within 10 cycles"); end
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      mem_drive();
      n_checks++;
      if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h200) begin
        n_fail++; $display("FAIL drop_target k=%0d: got req=%b addr=%h expected 1/200", k, bus.imem_req_o, bus.imem_addr_o);
      end
      n_checks++;
      if (bus.inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL drop_valid_new k=%0d: got %b expected 0", k, bus.inst_valid_o); end
      got = bus.imem_ack_i;
    end
    n_checks++; if (!got) begin n_fail++; $display("FAIL drop_new_ack: got no ack expected ack within 10 cycles"); end
    @(negedge clk);
    mem_drive();
    n_checks++;
    if (bus.inst_valid_o !== 1'b1 || bus.inst_addr_o !== 32'h200 || bus.inst_o !== word_of(32'h200)) begin
      n_fail++; $display("FAIL drop_head: got v=%b addr=%h inst=%h expected 1/200/%h", bus.inst_valid_o, bus.inst_addr_o, bus.inst_o, word_of(32'h200));
    end
    mem_lat = 0;
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    bus2.inst_ready_i = 1'b1;
    apply_reset(2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus2.imem_ack_i   = bus2.imem_req_o;
      bus2.imem_rdata_i = word_of(bus2.imem_addr_o);
      e = WRAP_PC + 32'(4 * k);
      n_checks++;
      if (bus2.imem_req_o !== 1'b1 || bus2.imem_addr_o !== e) begin
        n_fail++; $display("FAIL wrap_fetch k=%0d: got req=%b addr=%h expected 1/%h", k, bus2.imem_req_o, bus2.imem_addr_o, e);
      end
      if (k >= 1) begin
        e = WRAP_PC + 32'(4 * (k - 1));
        n_checks++;
        if (bus2.inst_valid_o !== 1'b1 || bus2.inst_addr_o !== e) begin
          n_fail++; $display("FAIL wrap_head k=%0d: got v=%b addr=%h expected 1/%h", k, bus2.inst_valid_o, bus2.inst_addr_o, e);
        end
      end
    end
    bus2.imem_ack_i = 1'b0;
  endtask

`ifdef FETCH_ALIGN_CHECK_EN
  task automatic test_align();
    logic [31:0] ea [5] = '{32'h0, 32'h4, 32'h100, 32'h104, 32'h108};
    bit          ev [5] = '{0, 1, 0, 1, 1};
    logic [31:0] eh [5] = '{32'h0, 32'h0, 32'h0, 32'h100, 32'h104};
    bit          em [5] = '{0, 0, 0, 1, 0};
    bus.inst_ready_i = 1'b1;
    apply_reset(2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      mem_drive();
      bus.branch_flag_i   = (k == 1);
      bus.branch_target_i = 32'h0000_0102;
      n_checks++;
      if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== ea[k]) begin
        n_fail++; $display("FAIL align_fetch k=%0d: got addr=%h expected %h", k, bus.imem_addr_o, ea[k]);
      end
      n_checks++;
      if (bus.inst_valid_o !== ev[k] || (ev[k] && (bus.inst_addr_o !== eh[k] || bus.inst_misalign_o !== em[k]))) begin
        n_fail++; $display("FAIL align_head k=%0d: got v=%b addr=%h mis=%b expected v=%b addr=%h mis=%b", k, bus.inst_valid_o, bus.inst_addr_o, bus.inst_misalign_o, ev[k], eh[k], em[k]);
      end
    end
    bus.branch_flag_i = 1'b0;
  endtask
`endif

  task automatic test_random();
    ent_t        mq[$];
    logic [31:0] exp_fetch = 32'h0;
    bit          stale = 1'b0;
    bit          mis_pend = 1'b0;
    bit          prev_wait = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    int          pops = 0;
    bit          br;
    logic [31:0] tgt;
    mem_rand = 1'b1;
    apply_reset(2);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      mem_drive();
      bus.inst_ready_i = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 11) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 1) == 0) tgt[1:0] = 2'b00;
      bus.branch_flag_i   = br;
      bus.branch_target_i = tgt;

      n_checks++;
      if (bus.inst_valid_o !== (mq.size() != 0)) begin
        n_fail++; $display("FAIL rnd_valid c=%0d: got %b expected %b", c, bus.inst_valid_o, (mq.size() != 0));
      end
      if (prev_wait) begin
        n_checks++;
        if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== prev_addr) begin
          n_fail++; $display("FAIL rnd_addr_hold c=%0d: got req=%b addr=%h expected 1/%h", c, bus.imem_req_o, bus.imem_addr_o, prev_addr);
        end
      end
      if (bus.inst_valid_o === 1'b1 && mq.size() != 0) begin
`ifdef FETCH_ALIGN_CHECK_EN
        n_checks++;
        if (bus.inst_misalign_o !== mq[0].m) begin
          n_fail++; $display("FAIL rnd_misalign c=%0d: got %b expected %b", c, bus.inst_misalign_o, mq[0].m);
        end
`endif
        if (bus.inst_ready_i) begin
          n_checks++;
          if (bus.inst_addr_o !== mq[0].a || bus.inst_o !== word_of(mq[0].a)) begin
            n_fail++; $display("FAIL rnd_pop c=%0d: got %h/%h expected addr %h", c, bus.inst_addr_o, bus.inst_o, mq[0].a);
          end
          void'(mq.pop_front());
          pops++;
        end
      end
      if (bus.imem_req_o && bus.imem_ack_i) begin
        if (br || stale) begin
          stale = 1'b0;
        end else begin
          n_checks++;
          if (bus.imem_addr_o !== exp_fetch) begin
            n_fail++; $display("FAIL rnd_fetch c=%0d: got %h expected %h", c, bus.imem_addr_o, exp_fetch);
          end
          n_checks++;
          if (mq.size() >= 2) begin
            n_fail++; $display("FAIL rnd_overfill c=%0d: got %0d entries before push expected at most 1", c, mq.size());
          end
          mq.push_back('{a: exp_fetch, m: mis_pend});
          mis_pend  = 1'b0;
          exp_fetch = exp_fetch + 32'd4;
        end
      end else if (br) begin
        stale = bus.imem_req_o;
      end
      if (br) begin
        mq.delete();
        exp_fetch = tgt & 32'hFFFF_FFFC;
        mis_pend  = |tgt[1:0];
      end
      prev_wait = bus.imem_req_o && !bus.imem_ack_i;
      prev_addr = bus.imem_addr_o;
    end
    bus.branch_flag_i = 1'b0;
    mem_rand = 1'b0;
    n_checks++;
    if (pops < 500) begin n_fail++; $display("FAIL rnd_progress: got %0d pops expected at least 500", pops); end
  endtask

  initial begin
    bus.branch_flag_i   = 1'b0;
    bus.branch_target_i = 32'h0;
    bus.imem_ack_i      = 1'b0;
    bus.imem_rdata_i    = 32'h0;
    bus.inst_ready_i    = 1'b1;
    bus2.branch_flag_i   = 1'b0;
    bus2.branch_target_i = 32'h0;
    bus2.imem_ack_i      = 1'b0;
    bus2.imem_rdata_i    = 32'h0;
    bus2.inst_ready_i    = 1'b1;
    test_reset();
    test_stream();
    test_stall_fill();
    test_same_cycle_branch();
    test_drop();
    test_wrap();
`ifdef FETCH_ALIGN_CHECK_EN
    test_align();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch front end of the flowCPU_mips pipeline. Sits directly upstream of the IF/ID register inside mips_sopc.
- Holds the PC and runs a req/ack handshake to instruction memory.
- Buffers returned words in a 2-entry queue and presents {inst, inst_addr} pairs to IF/ID with valid/ready flow control.
- Handles branch redirect, including flushing the queue and discarding an in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- QUEUE_DEPTH, 2, fetch-queue entries; fixed at 2, the only supported value.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high (`RESETABLE level asserts).
- branch_flag_i  input  1  redirect request from ID/EX.
- branch_target_i  input  32  redirect target address.
- imem_req_o  output  1  fetch request to instruction memory.
- imem_addr_o  output  32  fetch address; held stable while imem_req_o=1 and no ack.
- imem_ack_i  input  1  memory acknowledge; imem_rdata_i valid in the same cycle.
- imem_rdata_i  input  32  fetched instruction word.
- inst_valid_o  output  1  queue head valid.
- inst_o  output  32  queue head instruction.
- inst_addr_o  output  32  queue head address.
- inst_ready_i  input  1  IF/ID accepts this cycle (low = pipeline stall).

Behaviour:
- Reset values (asynchronous):
  - pc = RESET_PC; queue count = 0; state = S_IDLE.
  - imem_req_o = 0; imem_addr_o = RESET_PC.
  - inst_valid_o = 0; inst_o = 0; inst_addr_o = 0.
- FSM states: S_IDLE, S_REQ, S_WAITQ, S_DROP.
- S_IDLE: one cycle after rst deasserts, with req=0 (chip-enable delay). Then go to S_REQ.
- S_REQ: imem_req_o=1, imem_addr_o=pc.
  - On ack without branch: push {rdata, pc}; pc <= pc+4 (mod 2^32, 0xFFFF_FFFC wraps to 0).
  - Next state after ack: S_REQ if post-cycle count <= 1, else S_WAITQ.
- S_WAITQ: req=0. Go to S_REQ when count drops below 2.
- Branch handling (branch_flag_i=1, any state):
  - Queue flushed; count=0; inst_valid_o=0 next cycle.
  - pc <= branch_target_i.
  - Branch in S_REQ with ack in the same cycle: ack data discarded; next state S_REQ at target.
  - Branch in S_REQ without ack: go to S_DROP. Req stays high with the old address until ack; that ack's data is discarded; then S_REQ at target.
  - Branch in S_DROP: latest target wins; remain in S_DROP.
- Queue rules:
  - Pop when inst_valid_o && inst_ready_i.
  - Push and pop in the same cycle: count unchanged, order preserved (FIFO).
  - Push never occurs with count=2: a request is only issued when count <= 1, and pops only lower count.
  - Push when count=0: data appears on inst_o the next cycle (fetch-to-IF/ID latency = 1 cycle after ack).
  - Head outputs hold stable while inst_ready_i=0.
- Throughput: one instruction per cycle with a zero-wait-state memory (ack same cycle as req) and ready held high.
- Reset mid-request: all state is cleared immediately; any outstanding request is abandoned; memory is expected to be reset by the same rst.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- When defined:
  - Adds output port inst_misalign_o (1 bit).
  - Branch target with [1:0] != 0: pc loads the target with [1:0] forced to 00.
  - The next pushed entry carries a misalign flag, driven on inst_misalign_o while that entry is at the head.
  - Reset value 0.
- When undefined:
  - Port is absent.
  - Target low bits are forced to 00 silently.

Test Plan:
- Reset sequencing: rst=1 for 200 ns, then 0, zero-wait memory, ready=1 -> one idle cycle, then imem_addr_o = 0x0, 0x4, 0x8...; inst_addr_o follows one cycle after each ack; inst_valid_o continuous.
- Stall fill: ready=0 from first push -> exactly 2 entries captured (0x0, 0x4); req low in S_WAITQ. On ready=1: 0x0 pops, then 0x4; fetch resumes at 0x8.
- Same-cycle branch: branch at 0x100 coincident with ack for 0x8 -> 0x8 word never appears; next fetch address 0x100; queue empty for one cycle.
- Drop path: memory with 3-cycle ack latency; branch to 0x200 in the first wait cycle -> old ack discarded; next req at 0x200; no stale entry on inst_o.
- PC wrap: RESET_PC=0xFFFF_FFF8 -> fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Align check (FETCH_ALIGN_CHECK_EN): branch to 0x0000_0102 -> fetch address 0x100; inst_misalign_o=1 for that entry only.
